// File: rtl/stw_column_tester.sv
// rtl/stw_column_tester.sv - per-column stationary-weight self-test sequencer
// Optional feature: define STW_FAULT_INJECT_EN to add inject_en/inject_row fault injection.
module stw_column_tester #(
  parameter int          ROWS         = 4,
  parameter int          WORD_SIZE    = 16,
  parameter int          NUM_PATTERNS = 2,
  parameter int          LATENCY      = 2,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef STW_FAULT_INJECT_EN
  input  logic                      inject_en,
  input  logic [$clog2(ROWS)-1:0]   inject_row,
`endif
  output logic                      busy,
  output logic                      test_en,
  output logic [$clog2(ROWS)-1:0]   test_row_sel,
  output logic                      test_load_weight,
  output logic [WORD_SIZE-1:0]      test_weight,
  output logic [WORD_SIZE-1:0]      test_left,
  input  logic [WORD_SIZE-1:0]      test_obs,
  output logic [ROWS-1:0]           STW_result_mat,
  output logic                      STW_complete,
  output logic [$clog2(ROWS):0]     fault_count
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);
  localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PATTERNS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, APPLY, DRIVE, CHECK, DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_nxt;
  logic [15:0]     golden;
  logic [RW-1:0]   row;
  logic [PW-1:0]   pat;
  logic [CW-1:0]   cnt;
  logic [ROWS-1:0] result;
  logic [RW:0]     fcount;
  logic            complete;
  logic [WORD_SIZE-1:0] obs_eff;
  logic            mismatch;
  logic            last_pat;
  logic            last_row;

  // Fibonacci taps 16,14,13,11 expressed as a right shift with feedback into bit 15.
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign golden   = {8'h00, lfsr[7:0]} * {8'h00, lfsr[15:8]};
  assign last_pat = (pat == LAST_PAT);
  assign last_row = (row == LAST_ROW);

  always_comb begin
    obs_eff = test_obs;
`ifdef STW_FAULT_INJECT_EN
    obs_eff[0] = test_obs[0] ^ (inject_en && (row == inject_row));
`endif
    mismatch = (obs_eff != golden[WORD_SIZE-1:0]);
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    test_en          = 1'b0;
    test_load_weight = 1'b0;
    test_weight      = '0;
    test_left        = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = APPLY;
      end
      APPLY: begin
        busy             = 1'b1;
        test_en          = 1'b1;
        test_load_weight = 1'b1;
        test_weight      = WORD_SIZE'(lfsr[7:0]);
        state_nxt        = DRIVE;
      end
      DRIVE: begin
        busy        = 1'b1;
        test_en     = 1'b1;
        test_weight = WORD_SIZE'(lfsr[7:0]);
        test_left   = WORD_SIZE'(lfsr[15:8]);
        if (cnt == LAST_CNT) state_nxt = CHECK;
      end
      CHECK: begin
        busy        = 1'b1;
        test_en     = 1'b1;
        test_weight = WORD_SIZE'(lfsr[7:0]);
        test_left   = WORD_SIZE'(lfsr[15:8]);
        state_nxt   = (last_pat && last_row) ? DONE : APPLY;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED_EFF;
      row      <= '0;
      pat      <= '0;
      cnt      <= '0;
      result   <= '1;
      fcount   <= '0;
      complete <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            result   <= '1;
            fcount   <= '0;
            complete <= 1'b0;
            row      <= '0;
            pat      <= '0;
            cnt      <= '0;
          end
        end
        APPLY: cnt <= '0;
        DRIVE: cnt <= cnt + CW'(1);
        CHECK: begin
          lfsr <= lfsr_nxt;
          // A row is counted once, on its first failing pattern.
          if (mismatch) begin
            result[row] <= 1'b0;
            if (result[row]) fcount <= fcount + (RW+1)'(1);
          end
          if (!last_pat) begin
            pat <= pat + PW'(1);
          end else begin
            pat <= '0;
            if (!last_row) begin
              row <= row + RW'(1);
            end else begin
              row      <= '0;
              complete <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign test_row_sel   = row;
  assign STW_result_mat = result;
  assign STW_complete   = complete;
  assign fault_count    = fcount;

endmodule

// File: tb/tb_stw_column_tester.sv
// tb/tb_stw_column_tester.sv - self-checking bench for stw_column_tester
// Optional feature: STW_FAULT_INJECT_EN enables the fault-injection run.
module tb_stw_column_tester;

  localparam int ROWS  = 4;
  localparam int WS    = 16;
  localparam int NP    = 2;
  localparam int LAT   = 2;
  localparam int PER   = LAT + 2;
  localparam int TOTAL = ROWS * NP;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, test_en, test_load_weight, STW_complete;
  logic [1:0]    test_row_sel;
  logic [WS-1:0] test_weight, test_left, test_obs;
  logic [3:0]    STW_result_mat;
  logic [2:0]    fault_count;
`ifdef STW_FAULT_INJECT_EN
  logic       inject_en;
  logic [1:0] inject_row;
`endif

  stw_column_tester #(.ROWS(ROWS), .WORD_SIZE(WS), .NUM_PATTERNS(NP), .LATENCY(LAT), .SEED(16'hACE1)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef STW_FAULT_INJECT_EN
    .inject_en(inject_en),
    .inject_row(inject_row),
`endif
    .busy(busy),
    .test_en(test_en),
    .test_row_sel(test_row_sel),
    .test_load_weight(test_load_weight),
    .test_weight(test_weight),
    .test_left(test_left),
    .test_obs(test_obs),
    .STW_result_mat(STW_result_mat),
    .STW_complete(STW_complete),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  // Array column model: per-row weight register, product pipeline of depth LAT, fault overlays.
  logic [WS-1:0] w_reg [ROWS] = '{default: '0};
  logic [WS-1:0] pipe1 = '0, pipe2 = '0;
  logic [WS-1:0] prod_now;
  int load_idx = 0;
  int load_base = 0;
  int fault_mode = 0;
  int pat_now;

  always @(posedge clk) begin
    if (test_load_weight) begin
      w_reg[test_row_sel] <= test_weight;
      load_idx <= load_idx + 1;
    end
    pipe1 <= prod_now;
    pipe2 <= pipe1;
  end

  always_comb begin
    prod_now = test_en ? WS'(w_reg[test_row_sel] * test_left) : '0;
    pat_now  = (load_idx - load_base - 1) % NP;
    if (fault_mode == 1 && test_row_sel == 2'd2) prod_now = '0;
    if (fault_mode == 2 && (test_row_sel == 2'd0 || test_row_sel == 2'd3) && pat_now == 1)
      prod_now = prod_now ^ 16'h0001;
  end

  assign test_obs = pipe2;

  // Reference model: run position k counts cycles since start; pattern and phase follow from it.
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  bit          m_cmp  = 1'b0;
  int          m_k    = 0;
  int          m_fc   = 0;
  int          m_row;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [3:0]  m_res  = 4'hF;
  logic [15:0] m_exp, m_obs;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] fb;
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
    return (v >> 1) | (fb << 15);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_cmp = 0; m_k = 0; m_fc = 0;
      m_lfsr = 16'hACE1; m_res = 4'hF;
    end else if (m_run) begin
      if ((m_k - 1) % PER == PER - 1) begin
        m_row = ((m_k - 1) / PER) / NP;
        m_exp = 16'(m_lfsr[7:0]) * 16'(m_lfsr[15:8]);
        m_obs = test_obs;
`ifdef STW_FAULT_INJECT_EN
        if (inject_en && m_row == int'(inject_row)) m_obs[0] = ~m_obs[0];
`endif
        if (m_obs !== m_exp) begin
          if (m_res[m_row]) m_fc++;
          m_res[m_row] = 1'b0;
        end
        m_lfsr = lfsr_step(m_lfsr);
        if ((m_k - 1) / PER == TOTAL - 1) begin
          m_run = 0; m_done = 1; m_cmp = 1;
        end
      end
      m_k++;
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_run = 1; m_k = 1; m_res = 4'hF; m_fc = 0; m_cmp = 0;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;
  int loads = 0;
  int long_load = 0;
  bit prev_load = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int ph, rw;
    ph = (m_k - 1) % PER;
    rw = ((m_k - 1) / PER) / NP;
    if (m_run) begin
      check("busy", 32'(busy), 32'(1));
      check("test_en", 32'(test_en), 32'(1));
      check("test_row_sel", 32'(test_row_sel), rw);
      check("test_load_weight", 32'(test_load_weight), 32'(ph == 0));
      check("test_weight", 32'(test_weight), 32'(m_lfsr[7:0]));
      check("test_left", 32'(test_left), (ph == 0) ? 32'(0) : 32'(m_lfsr[15:8]));
    end else begin
      check("busy_idle", 32'(busy), 32'(0));
      check("test_en_idle", 32'(test_en), 32'(0));
      check("row_sel_idle", 32'(test_row_sel), 32'(0));
      check("load_idle", 32'(test_load_weight), 32'(0));
      check("operands_idle", 32'({test_weight, test_left}), 32'(0));
    end
    check("STW_complete", 32'(STW_complete), 32'(m_cmp));
    check("STW_result_mat", 32'(STW_result_mat), 32'(m_res));
    check("fault_count", 32'(fault_count), 32'(m_fc));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    if (test_load_weight === 1'b1) begin
      if (prev_load) long_load++;
      else loads++;
    end
    prev_load = (test_load_weight === 1'b1);
  endtask

  // Called at a negedge; start is raised for the current cycle (cycle 0).
  task automatic run(input int mode, input int re_a, input int re_b, input bit lit,
                     output int done_cyc, output int busy_cyc);
    int cyc;
    fault_mode = mode;
    load_base  = load_idx;
    loads = 0; long_load = 0;
    done_cyc = -1; busy_cyc = 0; cyc = 0;
    start = 1'b1;
    while (cyc < 200 && done_cyc < 0) begin
      tick();
      cyc++;
      start = (cyc == re_a || cyc == re_b);
      if (busy === 1'b1) busy_cyc++;
      if (cyc == 1) begin
        check("complete_drops", 32'(STW_complete), 32'(0));
        check("result_rearmed", 32'(STW_result_mat), 32'hF);
        if (lit) check("first_weight", 32'(test_weight), 32'h00E1);
      end
      if (lit && cyc == 2) check("first_left", 32'(test_left), 32'h00AC);
      if (lit && cyc == 5) check("second_weight", 32'(test_weight), 32'h0070);
      if (lit && cyc == 6) check("second_left", 32'(test_left), 32'h0056);
      if (cyc >= 1 && STW_complete === 1'b1) done_cyc = cyc;
    end
    start = 1'b0;
  endtask

  int dc, bc;

  initial begin
    rst = 1'b1; start = 1'b0;
`ifdef STW_FAULT_INJECT_EN
    inject_en = 1'b0; inject_row = 2'd0;
`endif
    tick(); tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_result", 32'(STW_result_mat), 32'hF);
    check("rst_complete", 32'(STW_complete), 32'(0));
    check("rst_fault_count", 32'(fault_count), 32'(0));
    rst = 1'b0;
    tick();

    // Golden run
    run(0, -1, -1, 1'b1, dc, bc);
    check("golden_done_cycle", dc, 33);
    check("golden_busy_cycles", bc, 32);
    check("golden_result", 32'(STW_result_mat), 32'hF);
    check("golden_fault_count", 32'(fault_count), 32'(0));
    check("golden_loads", loads, 8);
    // start in the cycle completion rises is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_busy", 32'(busy), 32'(0));
    check("done_start_complete", 32'(STW_complete), 32'(1));
    tick();

    // Row 2 stuck at zero
    run(1, -1, -1, 1'b0, dc, bc);
    check("stuck_done_cycle", dc, 33);
    check("stuck_result", 32'(STW_result_mat), 32'hB);
    check("stuck_fault_count", 32'(fault_count), 32'(1));
    check("stuck_loads", loads, 8);
    check("stuck_long_load", long_load, 0);
    tick(); tick();

    // Rows 0 and 3 fail only on pattern 1
    run(2, -1, -1, 1'b0, dc, bc);
    check("p1_result", 32'(STW_result_mat), 32'h6);
    check("p1_fault_count", 32'(fault_count), 32'(2));
    tick();

    // Re-pulsed start mid-run
    run(0, 5, 20, 1'b0, dc, bc);
    check("repulse_done_cycle", dc, 33);
    check("repulse_busy_cycles", bc, 32);
    check("repulse_result", 32'(STW_result_mat), 32'hF);
    tick();

    // Reset at cycle 12 of a run
    fault_mode = 0;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_complete", 32'(STW_complete), 32'(0));
    check("midrst_result", 32'(STW_result_mat), 32'hF);
    check("midrst_fault_count", 32'(fault_count), 32'(0));
    tick();
    run(0, -1, -1, 1'b1, dc, bc);
    check("postrst_done_cycle", dc, 33);
    check("postrst_result", 32'(STW_result_mat), 32'hF);
    tick();

`ifdef STW_FAULT_INJECT_EN
    inject_en = 1'b1; inject_row = 2'd1;
    run(0, -1, -1, 1'b0, dc, bc);
    check("inject_result", 32'(STW_result_mat), 32'hD);
    check("inject_fault_count", 32'(fault_count), 32'(1));
    inject_en = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stw_column_tester.md
Name: stw_column_tester

Overview:
Per-column stationary-weight self-test (STW) sequencer that sits directly upstream of the column's recompute controller. On a start pulse it walks every row of one systolic column and loads LFSR-generated test weights and left operands. It compares each PE's observed product against a golden product. It produces the per-row pass vector `STW_result_mat` (1 = pass) and the `STW_complete` flag that the recompute controller consumes.

Parameters:
ROWS, 4, number of PE rows in the column (power of two, >=2)
WORD_SIZE, 16, datapath width (8..16)
NUM_PATTERNS, 2, test patterns applied per row (>=1)
LATENCY, 2, cycles from operand drive to a valid `test_obs` (>=1)
SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'hACE1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse that begins a test run
busy  out  1  high while a run is in progress
test_en  out  1  steers the array column into test mode
test_row_sel  out  $clog2(ROWS)  row currently under test
test_load_weight  out  1  one-cycle weight-load strobe for the selected PE
test_weight  out  WORD_SIZE  test weight
test_left  out  WORD_SIZE  test left operand (top input held 0 by the array in test mode)
test_obs  in  WORD_SIZE  observed output of the selected PE
STW_result_mat  out  ROWS  per-row pass bits; bit r = row r
STW_complete  out  1  run finished, results valid
fault_count  out  $clog2(ROWS)+1  number of failing rows

Behaviour:
- Reset values:
  - busy=0, test_en=0, test_row_sel=0, test_load_weight=0, test_weight=0, test_left=0
  - STW_result_mat=all ones (downstream sees no fault), STW_complete=0, fault_count=0
  - LFSR=SEED, state=IDLE
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances exactly once per pattern, on leaving CHECK.
- Pattern operands:
  - weight = zero-extended lfsr[7:0]
  - left = zero-extended lfsr[15:8]
  - expected = (weight*left)[WORD_SIZE-1:0]
- States and transitions:
  - IDLE: waits for start. On start: STW_result_mat <= all ones, fault_count <= 0, STW_complete <= 0, row=0, pattern=0, busy <= 1, then go to APPLY.
  - APPLY (1 cycle): test_en=1, test_load_weight=1, test_weight driven, test_row_sel=row. Go to DRIVE.
  - DRIVE (LATENCY cycles): test_load_weight=0, test_left driven, test_weight held. Go to CHECK when the cycle counter reaches LATENCY-1.
  - CHECK (1 cycle): sample test_obs. On mismatch, clear STW_result_mat[row]; fault_count increments only if that bit was still 1 (counts rows, not patterns). Advance the LFSR.
    - If pattern<NUM_PATTERNS-1: pattern++ and go to APPLY.
    - Else, if row<ROWS-1: pattern=0, row++ and go to APPLY.
    - Else go to DONE.
  - DONE: busy=0, test_en=0, operands=0, STW_complete=1. Results and STW_complete hold. Return to IDLE in the same cycle so that a later start restarts the run.
- Run latency: start sampled at cycle 0 → STW_complete high at cycle 1+ROWS*NUM_PATTERNS*(LATENCY+2).
- start while busy: ignored; no restart, no result change.
- start in the same cycle STW_complete rises: ignored.
- start after completion: STW_complete drops the next cycle; results reset to all ones.
- The LFSR is not reseeded between runs, so successive runs use fresh patterns.
- rst mid-run: everything returns to its reset value within one cycle; no partial results are kept.
- STW_result_mat must be stable whenever STW_complete=1.

Optional Feature:
STW_FAULT_INJECT_EN:
- Defined: adds inputs inject_en (1) and inject_row ($clog2(ROWS)). When inject_en=1 and row==inject_row, the sampled test_obs has bit 0 inverted before comparison, forcing that row to fail. Used for BISR bring-up without a faulty array.
- Undefined: these ports and this logic do not exist; the comparison uses test_obs directly.

Test Plan:
- Golden array model (ROWS=4, NUM_PATTERNS=2, LATENCY=2), start pulse → busy for 32 cycles; STW_complete high at cycle 33; STW_result_mat=4'b1111; fault_count=0.
- Model with row 2 output stuck at 0 → STW_result_mat=4'b1011, fault_count=1. test_load_weight pulses 8 times in total, each exactly 1 cycle long.
- Rows 0 and 3 fail only on pattern 1 → STW_result_mat=4'b0110, fault_count=2 (count not doubled).
- Start re-pulsed at cycles 5 and 20 of a run → completion time and results identical to a single start.
- rst asserted at cycle 12 of a run → next cycle: busy=0, STW_complete=0, STW_result_mat=4'b1111, LFSR=SEED. A subsequent start completes a normal run.
- STW_FAULT_INJECT_EN defined, inject_en=1, inject_row=1, golden model → STW_result_mat=4'b1101, fault_count=1.
